// File: rtl/tmr_recovery_ctrl.sv
// Recovery sequencer for the TMR core: isolates and reloads a single faulty
// core, or rolls all three back to the buffered PC with a bounded retry count.
module tmr_recovery_ctrl #(
   parameter int unsigned RESYNC_CYCLES = 4,
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned MAX_RETRY     = 3,
   parameter int unsigned CLEAN_WINDOW  = 64,
   parameter int unsigned CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst_in,
   input  logic [2:0]       voter_state,
   input  logic [31:0]      pc_voted,
   input  logic [31:0]      pc_rollback,
   output logic             stall,
   output logic [2:0]       core_rst_n,
   output logic [2:0]       pc_load,
   output logic [31:0]      pc_load_val,
   output logic             busy,
   output logic             fatal,
   output logic [1:0]       faulty_core,
   output logic [1:0]       retry_cnt,
   output logic [CNT_W-1:0] fault_cnt_a,
   output logic [CNT_W-1:0] fault_cnt_b,
   output logic [CNT_W-1:0] fault_cnt_c
);

   localparam int unsigned TMAX = (RESYNC_CYCLES > SETTLE_CYCLES) ?
                                  RESYNC_CYCLES : SETTLE_CYCLES;
   localparam int unsigned TW   = $clog2(TMAX + 1);
   localparam int unsigned CW   = $clog2(CLEAN_WINDOW + 1);

   typedef enum logic [2:0] {
      IDLE, ISOLATE, RELOAD, ROLLBACK, SETTLE, FATAL
   } state_t;

   state_t         state_q, state_d;
   logic [TW-1:0]  tmr_q, tmr_d;
   logic [1:0]     idx_q, idx_d;
   logic [31:0]    pc_lat_q, pc_lat_d;
   logic [CW-1:0]  clean_q;

   logic           is_ok, is_single;
   logic [1:0]     fault_idx;

   logic           stall_d;
   logic [2:0]     core_rst_n_d;
   logic [2:0]     pc_load_d;
   logic [31:0]    pc_load_val_d;

   always_comb begin
      is_ok     = 1'b0;
      is_single = 1'b0;
      fault_idx = 2'd0;
      case (voter_state)
         3'b111:  is_ok = 1'b1;
         3'b010:  begin is_single = 1'b1; fault_idx = 2'd0; end
         3'b001:  begin is_single = 1'b1; fault_idx = 2'd1; end
         3'b100:  begin is_single = 1'b1; fault_idx = 2'd2; end
         default: ;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      tmr_d    = tmr_q;
      idx_d    = idx_q;
      pc_lat_d = pc_lat_q;
      unique case (state_q)
         IDLE: begin
            if (is_single) begin
               state_d  = ISOLATE;
               tmr_d    = '0;
               idx_d    = fault_idx;
               pc_lat_d = pc_voted;
            end else if (!is_ok) begin
               if (retry_cnt == 2'(MAX_RETRY)) begin
                  state_d = FATAL;
               end else begin
                  state_d  = ROLLBACK;
                  pc_lat_d = pc_rollback;
               end
            end
         end
         ISOLATE: begin
            if (tmr_q == TW'(RESYNC_CYCLES - 1)) state_d = RELOAD;
            else tmr_d = tmr_q + 1'b1;
         end
         RELOAD, ROLLBACK: begin
            state_d = SETTLE;
            tmr_d   = '0;
         end
         SETTLE: begin
            if (tmr_q == TW'(SETTLE_CYCLES - 1)) state_d = IDLE;
            else tmr_d = tmr_q + 1'b1;
         end
         FATAL:   state_d = FATAL;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they register in step with it.
   always_comb begin
      stall_d       = (state_d != IDLE);
      core_rst_n_d  = 3'b111;
      pc_load_d     = 3'b000;
      pc_load_val_d = pc_load_val;
      unique case (1'b1)
         state_d == ISOLATE:  core_rst_n_d = ~(3'b001 << idx_d);
         state_d == RELOAD: begin
            pc_load_d     = 3'b001 << idx_d;
            pc_load_val_d = pc_lat_d;
         end
         state_d == ROLLBACK: begin
            pc_load_d     = 3'b111;
            pc_load_val_d = pc_lat_d;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         state_q     <= IDLE;
         tmr_q       <= '0;
         idx_q       <= '0;
         pc_lat_q    <= '0;
         clean_q     <= '0;
         stall       <= 1'b0;
         busy        <= 1'b0;
         fatal       <= 1'b0;
         core_rst_n  <= 3'b111;
         pc_load     <= 3'b000;
         pc_load_val <= '0;
         faulty_core <= 2'd0;
         retry_cnt   <= 2'd0;
         fault_cnt_a <= '0;
         fault_cnt_b <= '0;
         fault_cnt_c <= '0;
      end else begin
         state_q     <= state_d;
         tmr_q       <= tmr_d;
         idx_q       <= idx_d;
         pc_lat_q    <= pc_lat_d;
         stall       <= stall_d;
         busy        <= stall_d;
         fatal       <= (state_d == FATAL);
         core_rst_n  <= core_rst_n_d;
         pc_load     <= pc_load_d;
         pc_load_val <= pc_load_val_d;
         if (state_q == IDLE) begin
            if (is_ok) begin
               if (clean_q != CW'(CLEAN_WINDOW)) clean_q <= clean_q + 1'b1;
               if (clean_q >= CW'(CLEAN_WINDOW - 1)) retry_cnt <= 2'd0;
            end else begin
               clean_q <= '0;
               if (is_single) begin
                  faulty_core <= fault_idx + 2'd1;
                  unique case (fault_idx)
                     2'd0: if (fault_cnt_a != '1) fault_cnt_a <= fault_cnt_a + 1'b1;
                     2'd1: if (fault_cnt_b != '1) fault_cnt_b <= fault_cnt_b + 1'b1;
                     2'd2: if (fault_cnt_c != '1) fault_cnt_c <= fault_cnt_c + 1'b1;
                     default: ;
                  endcase
               end else if (retry_cnt != 2'(MAX_RETRY)) begin
                  retry_cnt <= retry_cnt + 2'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_tmr_recovery_ctrl.sv
// Directed bench for tmr_recovery_ctrl: isolation, rollback, retry limit,
// clean-window clearing, async abort and counter saturation.
module tb_tmr_recovery_ctrl;

   logic        clk = 1'b0;
   logic        rst_in = 1'b1;
   logic [2:0]  voter_state = 3'b111;
   logic [31:0] pc_voted = '0;
   logic [31:0] pc_rollback = '0;
   logic        stall;
   logic [2:0]  core_rst_n;
   logic [2:0]  pc_load;
   logic [31:0] pc_load_val;
   logic        busy;
   logic        fatal;
   logic [1:0]  faulty_core;
   logic [1:0]  retry_cnt;
   logic [7:0]  fault_cnt_a;
   logic [7:0]  fault_cnt_b;
   logic [7:0]  fault_cnt_c;

   int checks = 0;
   int failures = 0;

   tmr_recovery_ctrl dut (
      .clk(clk), .rst_in(rst_in), .voter_state(voter_state),
      .pc_voted(pc_voted), .pc_rollback(pc_rollback),
      .stall(stall), .core_rst_n(core_rst_n), .pc_load(pc_load),
      .pc_load_val(pc_load_val), .busy(busy), .fatal(fatal),
      .faulty_core(faulty_core), .retry_cnt(retry_cnt),
      .fault_cnt_a(fault_cnt_a), .fault_cnt_b(fault_cnt_b),
      .fault_cnt_c(fault_cnt_c)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      voter_state = 3'b111;
      @(negedge clk);
      rst_in = 1'b0;
      repeat (2) @(negedge clk);
      rst_in = 1'b1;
      @(negedge clk);
   endtask

   task automatic rollback_once();
      voter_state = 3'b000;
      @(negedge clk);
      voter_state = 3'b111;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      #2 rst_in = 1'b0;
      @(negedge clk);
      checks++;
      if ({stall, busy, fatal} !== 3'b000) begin
         failures++;
         $display("FAIL reset_flags got=%b want=000", {stall, busy, fatal});
      end
      checks++;
      if ({core_rst_n, pc_load} !== 6'b111_000) begin
         failures++;
         $display("FAIL reset_core got=%b want=111000", {core_rst_n, pc_load});
      end
      checks++;
      if ({pc_load_val, faulty_core, retry_cnt} !== 36'h0) begin
         failures++;
         $display("FAIL reset_regs got=%h want=0", {pc_load_val, faulty_core, retry_cnt});
      end
      checks++;
      if ({fault_cnt_a, fault_cnt_b, fault_cnt_c} !== 24'h0) begin
         failures++;
         $display("FAIL reset_cnts got=%h want=0", {fault_cnt_a, fault_cnt_b, fault_cnt_c});
      end
      rst_in = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_idle_ok();
      int bad = 0;
      voter_state = 3'b111;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if ({stall, busy, core_rst_n, pc_load} !== 8'b0_0_111_000) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL idle_quiet got=%0d bad cycles want=0", bad);
      end
      checks++;
      if ({retry_cnt, fault_cnt_a, fault_cnt_b, fault_cnt_c} !== 26'h0) begin
         failures++;
         $display("FAIL idle_cnts got=%h want=0",
                  {retry_cnt, fault_cnt_a, fault_cnt_b, fault_cnt_c});
      end
   endtask

   task automatic test_single_fault();
      int bad = 0;
      voter_state = 3'b010;
      pc_voted    = 32'h100;
      @(negedge clk);
      voter_state = 3'b111;
      pc_voted    = 32'hDEAD;
      for (int i = 0; i < 4; i++) begin
         if ({stall, busy, core_rst_n, pc_load} !== 8'b1_1_110_000) bad++;
         @(negedge clk);
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL isolate_a got=%0d bad cycles want=0", bad);
      end
      checks++;
      if ({stall, core_rst_n, pc_load, pc_load_val} !== {1'b1, 3'b111, 3'b001, 32'h100}) begin
         failures++;
         $display("FAIL reload_a got=%b/%b/%b/%h want=1/111/001/100",
                  stall, core_rst_n, pc_load, pc_load_val);
      end
      bad = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if ({stall, busy, core_rst_n, pc_load} !== 8'b1_1_111_000) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL settle_a got=%0d bad cycles want=0", bad);
      end
      @(negedge clk);
      checks++;
      if ({stall, busy, pc_load} !== 5'b0_0_000) begin
         failures++;
         $display("FAIL release_a got=%b want=00000", {stall, busy, pc_load});
      end
      checks++;
      if ({fault_cnt_a, faulty_core} !== {8'd1, 2'd1}) begin
         failures++;
         $display("FAIL count_a got=%0d/%0d want=1/1", fault_cnt_a, faulty_core);
      end
   endtask

   task automatic test_rollback();
      voter_state = 3'b000;
      pc_rollback = 32'h0C0;
      @(negedge clk);
      voter_state = 3'b010;
      checks++;
      if ({stall, pc_load, pc_load_val, retry_cnt} !== {1'b1, 3'b111, 32'h0C0, 2'd1}) begin
         failures++;
         $display("FAIL rollback_load got=%b/%b/%h/%0d want=1/111/0c0/1",
                  stall, pc_load, pc_load_val, retry_cnt);
      end
      checks++;
      if (faulty_core !== 2'd1) begin
         failures++;
         $display("FAIL rollback_keep_faulty got=%0d want=1", faulty_core);
      end
      @(negedge clk);
      voter_state = 3'b000;
      checks++;
      if ({stall, pc_load} !== 4'b1_000) begin
         failures++;
         $display("FAIL settle_rb1 got=%b want=1000", {stall, pc_load});
      end
      @(negedge clk);
      voter_state = 3'b110;
      checks++;
      if ({stall, pc_load} !== 4'b1_000) begin
         failures++;
         $display("FAIL settle_rb2 got=%b want=1000", {stall, pc_load});
      end
      @(negedge clk);
      voter_state = 3'b111;
      checks++;
      if ({stall, busy, pc_load, retry_cnt, fault_cnt_a} !== {5'b0_0_000, 2'd1, 8'd1}) begin
         failures++;
         $display("FAIL settle_ignore got=%b/%b/%b/%0d/%0d want=0/0/000/1/1",
                  stall, busy, pc_load, retry_cnt, fault_cnt_a);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL settle_ignore_idle got=%b want=0", busy);
      end
   endtask

   task automatic test_fatal();
      int bad = 0;
      do_reset();
      repeat (3) rollback_once();
      checks++;
      if (retry_cnt !== 2'd3) begin
         failures++;
         $display("FAIL retry_three got=%0d want=3", retry_cnt);
      end
      voter_state = 3'b000;
      @(negedge clk);
      voter_state = 3'b111;
      checks++;
      if ({stall, fatal, busy, pc_load, core_rst_n} !== 9'b1_1_1_000_111) begin
         failures++;
         $display("FAIL fatal_enter got=%b want=111000111",
                  {stall, fatal, busy, pc_load, core_rst_n});
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if ({stall, fatal, pc_load, core_rst_n} !== 8'b1_1_000_111) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL fatal_sticky got=%0d bad cycles want=0", bad);
      end
      #2 rst_in = 1'b0;
      #1;
      checks++;
      if ({stall, fatal, busy} !== 3'b000) begin
         failures++;
         $display("FAIL fatal_clear got=%b want=000", {stall, fatal, busy});
      end
      @(negedge clk);
      rst_in = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_clean_window();
      do_reset();
      repeat (3) rollback_once();
      repeat (63) @(negedge clk);
      checks++;
      if (retry_cnt !== 2'd3) begin
         failures++;
         $display("FAIL clean_63 got=%0d want=3", retry_cnt);
      end
      @(negedge clk);
      checks++;
      if (retry_cnt !== 2'd0) begin
         failures++;
         $display("FAIL clean_64 got=%0d want=0", retry_cnt);
      end
      voter_state = 3'b000;
      @(negedge clk);
      voter_state = 3'b111;
      checks++;
      if ({retry_cnt, fatal, pc_load} !== {2'd1, 1'b0, 3'b111}) begin
         failures++;
         $display("FAIL clean_retry got=%0d/%b/%b want=1/0/111", retry_cnt, fatal, pc_load);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_abort();
      int bad = 0;
      do_reset();
      voter_state = 3'b001;
      pc_voted    = 32'h200;
      @(negedge clk);
      voter_state = 3'b111;
      checks++;
      if ({stall, core_rst_n, faulty_core} !== {1'b1, 3'b101, 2'd2}) begin
         failures++;
         $display("FAIL isolate_b got=%b/%b/%0d want=1/101/2", stall, core_rst_n, faulty_core);
      end
      @(negedge clk);
      #2 rst_in = 1'b0;
      #1;
      checks++;
      if ({stall, busy, core_rst_n, pc_load, faulty_core, fault_cnt_b} !==
          {1'b0, 1'b0, 3'b111, 3'b000, 2'd0, 8'd0}) begin
         failures++;
         $display("FAIL abort_regs got=%b/%b/%b/%b/%0d/%0d want=0/0/111/000/0/0",
                  stall, busy, core_rst_n, pc_load, faulty_core, fault_cnt_b);
      end
      @(negedge clk);
      rst_in = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if ({busy, pc_load} !== 4'b0_000) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL abort_no_load got=%0d bad cycles want=0", bad);
      end
   endtask

   task automatic test_back_to_back_saturate();
      int waited = 0;
      do_reset();
      voter_state = 3'b100;
      repeat (2032) @(negedge clk);
      checks++;
      if (fault_cnt_c !== 8'd254) begin
         failures++;
         $display("FAIL sat_254 got=%0d want=254", fault_cnt_c);
      end
      @(negedge clk);
      checks++;
      if ({fault_cnt_c, core_rst_n, faulty_core} !== {8'd255, 3'b011, 2'd3}) begin
         failures++;
         $display("FAIL sat_255 got=%0d/%b/%0d want=255/011/3",
                  fault_cnt_c, core_rst_n, faulty_core);
      end
      repeat (24) @(negedge clk);
      voter_state = 3'b111;
      while (busy === 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL sat_idle_timeout got=%b want=0", busy);
      end
      checks++;
      if ({fault_cnt_c, fault_cnt_a, fault_cnt_b} !== {8'd255, 8'd0, 8'd0}) begin
         failures++;
         $display("FAIL sat_hold got=%0d/%0d/%0d want=255/0/0",
                  fault_cnt_c, fault_cnt_a, fault_cnt_b);
      end
   endtask

   initial begin
      test_reset();
      test_idle_ok();
      test_single_fault();
      test_rollback();
      test_fatal();
      test_clean_window();
      test_abort();
      test_back_to_back_saturate();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
